// File: rtl/vend_pkg.sv
// Shared types and default timing for the vending dispense sequencer.
// Holds the controller state encoding and the default parameter values.
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MOTOR     = 3'd1,
    S_WAIT_DROP = 3'd2,
    S_SOLENOID  = 3'd3,
    S_GAP       = 3'd4,
    S_FAULT     = 3'd5
  } vend_state_e;

  localparam int MOTOR_CYC_DEF = 50;
  localparam int SOL_CYC_DEF   = 20;
  localparam int DROP_TMO_DEF  = 1000;
  localparam int GAP_CYC_DEF   = 4;
  localparam int PEND_W_DEF    = 3;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vend_pend_cnt.sv
// Saturating up/down pending-job counter with a sticky drop flag.
// A request arriving at full scale is discarded and raises drop.
module vend_pend_cnt import vend_pkg::*; #(
  parameter int W = PEND_W_DEF
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         drop_clr,
  output logic [W-1:0] cnt,
  output logic         drop
);

  localparam logic [W-1:0] MAX = '1;

  logic sat;
  logic up;
  logic dn;

  assign sat = (cnt == MAX);
  assign up  = inc & ~sat;
  assign dn  = dec & (cnt != '0);

  // count owed jobs; simultaneous up and down cancel
  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      cnt <= '0;
    else if (up & ~dn)
      cnt <= cnt + 1'b1;
    else if (dn & ~up)
      cnt <= cnt - 1'b1;
  end

  // remember that a request was lost to saturation
  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      drop <= 1'b0;
    else if (drop_clr)
      drop <= 1'b0;
    else if (inc & sat)
      drop <= 1'b1;
  end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Actuator sequencer: queues cola/change pulses, runs motor and solenoid jobs.
// Optional macro VEND_DISPENSE_STATS_EN adds the po_vend_cnt sensed-drop counter.
module vend_dispense_ctrl import vend_pkg::*; #(
  parameter int MOTOR_CYC = MOTOR_CYC_DEF,
  parameter int SOL_CYC   = SOL_CYC_DEF,
  parameter int DROP_TMO  = DROP_TMO_DEF,
  parameter int GAP_CYC   = GAP_CYC_DEF,
  parameter int PEND_W    = PEND_W_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              pi_cola_req,
  input  logic              pi_change_req,
  input  logic              pi_drop_sense,
  input  logic              pi_fault_clr,
  output logic              po_motor_en,
  output logic              po_solenoid_en,
  output logic              po_busy,
  output logic              po_fault,
  output logic [PEND_W-1:0] po_cola_pend,
  output logic [PEND_W-1:0] po_change_pend,
  output logic              po_req_drop
`ifdef VEND_DISPENSE_STATS_EN
  ,
  output logic [15:0]       po_vend_cnt
`endif
);

  localparam int TMAX = max_of(max_of(MOTOR_CYC, SOL_CYC),
                               max_of(DROP_TMO, GAP_CYC));
  localparam int TW   = $clog2(TMAX + 1);

  vend_state_e       state;
  vend_state_e       state_n;
  logic [TW-1:0]     tmr;
  logic [TW-1:0]     tmr_ld;
  logic              tmr_done;
  logic              seen;
  logic [PEND_W-1:0] cola_pend;
  logic [PEND_W-1:0] chg_pend;
  logic              cola_drop;
  logic              chg_drop;
  logic              start_cola;
  logic              start_chg;
  logic              motor_d;
  logic              sol_d;
  logic              busy_d;
  logic              fault_d;

  assign tmr_done   = (tmr == '0);
  assign start_cola = (state == S_IDLE) && (cola_pend != '0);
  assign start_chg  = (state == S_IDLE) && (cola_pend == '0)
                      && (chg_pend != '0);

  vend_pend_cnt #(.W(PEND_W)) u_cola_cnt (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .inc      (pi_cola_req),
    .dec      (start_cola),
    .drop_clr (pi_fault_clr),
    .cnt      (cola_pend),
    .drop     (cola_drop)
  );

  vend_pend_cnt #(.W(PEND_W)) u_chg_cnt (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .inc      (pi_change_req),
    .dec      (start_chg),
    .drop_clr (pi_fault_clr),
    .cnt      (chg_pend),
    .drop     (chg_drop)
  );

  assign po_cola_pend   = cola_pend;
  assign po_change_pend = chg_pend;
  assign po_req_drop    = cola_drop | chg_drop;

  // state, phase timer and early-sense flag
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= S_IDLE;
      tmr   <= '0;
      seen  <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state)
        tmr <= tmr_ld;
      else if (!tmr_done)
        tmr <= tmr - 1'b1;
      if (state_n == S_MOTOR && state != S_MOTOR)
        seen <= 1'b0;
      else if (state == S_MOTOR && pi_drop_sense)
        seen <= 1'b1;
    end
  end

  // next state: cans before change, one job at a time
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (start_cola)
          state_n = S_MOTOR;
        else if (start_chg)
          state_n = S_SOLENOID;
      end
      S_MOTOR: begin
        if (tmr_done)
          state_n = S_WAIT_DROP;
      end
      S_WAIT_DROP: begin
        if (seen | pi_drop_sense)
          state_n = S_GAP;
        else if (tmr_done)
          state_n = S_FAULT;
      end
      S_SOLENOID: begin
        if (tmr_done)
          state_n = S_GAP;
      end
      S_GAP: begin
        if (tmr_done)
          state_n = S_IDLE;
      end
      S_FAULT: begin
        if (pi_fault_clr)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // timer reload value for the state being entered
  always_comb begin
    tmr_ld = '0;
    unique case (state_n)
      S_MOTOR:     tmr_ld = TW'(MOTOR_CYC - 1);
      S_WAIT_DROP: tmr_ld = TW'(DROP_TMO - 1);
      S_SOLENOID:  tmr_ld = TW'(SOL_CYC - 1);
      S_GAP:       tmr_ld = TW'(GAP_CYC - 1);
      default:     tmr_ld = '0;
    endcase
  end

  // output decode from the upcoming state
  always_comb begin
    motor_d = (state_n == S_MOTOR);
    sol_d   = (state_n == S_SOLENOID);
    busy_d  = (state_n != S_IDLE);
    fault_d = (state_n == S_FAULT);
  end

  // registered actuator and status outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      po_motor_en    <= 1'b0;
      po_solenoid_en <= 1'b0;
      po_busy        <= 1'b0;
      po_fault       <= 1'b0;
    end else begin
      po_motor_en    <= motor_d;
      po_solenoid_en <= sol_d;
      po_busy        <= busy_d;
      po_fault       <= fault_d;
    end
  end

`ifdef VEND_DISPENSE_STATS_EN
  // count cans confirmed by the drop sensor
  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      po_vend_cnt <= '0;
    else if (state == S_WAIT_DROP && state_n == S_GAP)
      po_vend_cnt <= po_vend_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
Downstream sequencer for the vending machine FSM outputs. It takes the single-cycle po_cola / po_money pulses and queues them in pending counters. It then drives the can-dispense motor and the change-return solenoid one job at a time, with timed pulses and a can-drop sensor handshake. It sits between the vending machine core and the physical actuators.

Parameters:
MOTOR_CYC, 50, cycles po_motor_en is held high per can (>=1)
SOL_CYC, 20, cycles po_solenoid_en is held high per change coin (>=1)
DROP_TMO, 1000, max cycles to wait for pi_drop_sense after motor stops
GAP_CYC, 4, idle cycles between consecutive actuator jobs (>=1)
PEND_W, 3, width of each pending counter (saturates at 2^PEND_W-1)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst  in  1  synchronous reset, active-high
pi_cola_req  in  1  1-cycle pulse, one can owed (from vending machine po_cola)
pi_change_req  in  1  1-cycle pulse, one coin of change owed (from po_money)
pi_drop_sense  in  1  can-drop sensor, synchronous, high >=1 cycle per can
pi_fault_clr  in  1  1-cycle pulse, leave FAULT
po_motor_en  out  1  dispense motor drive
po_solenoid_en  out  1  change-return solenoid drive
po_busy  out  1  high whenever state != IDLE
po_fault  out  1  high in FAULT
po_cola_pend  out  PEND_W  cans still owed
po_change_pend  out  PEND_W  coins still owed
po_req_drop  out  1  sticky: a request arrived while its counter was saturated; cleared by reset or pi_fault_clr

Behaviour:
- Reset: all outputs 0, both counters 0, state IDLE, timers 0. A reset mid-job aborts it immediately; actuators go low next edge and pending work is lost.
- All outputs are registered. A request pulse at edge N is visible on *_pend after edge N.
- Counter update per cycle: +1 on request, -1 on job start; both in the same cycle gives net 0. A request at max value is dropped and sets po_req_drop. A decrement never happens at 0.
- FSM states: IDLE, MOTOR, WAIT_DROP, SOLENOID, GAP, FAULT.
- IDLE: if cola_pend!=0, go to MOTOR (cola has priority); else if change_pend!=0, go to SOLENOID. The start decrements the chosen counter. The start decision uses registered counts, so a request at edge N starts a job at edge N+1 at the earliest.
- MOTOR: po_motor_en=1 for exactly MOTOR_CYC cycles, then go to WAIT_DROP. A pi_drop_sense during MOTOR is latched in a seen flag.
- WAIT_DROP: motor off. If the seen flag is set or pi_drop_sense=1, go to GAP. If DROP_TMO cycles elapse without either, go to FAULT; the can is not re-queued.
- SOLENOID: po_solenoid_en=1 for exactly SOL_CYC cycles, then go to GAP. No sensor is involved.
- GAP: all actuators low for GAP_CYC cycles, then go to IDLE. After a cola job, change is still served only when cola_pend==0, so all cans go before any change.
- FAULT: actuators low, po_fault=1. Requests still increment the counters. pi_fault_clr moves to IDLE next edge and clears po_req_drop. pi_drop_sense is ignored here.
- po_motor_en and po_solenoid_en are never high in the same cycle.
- Timers are sized with $clog2 of the largest parameter and reload on every state entry.

Optional Feature:
VEND_DISPENSE_STATS_EN:
- Defined: adds output po_vend_cnt[15:0]. It counts cola jobs that exit WAIT_DROP to GAP, wraps at 65535→0, and is reset only by sys_rst.
- Undefined: the port and its logic are absent; everything else is identical.

Decomposition:
- Shared package vend_pkg holds:
  - the state enum (3-bit encoding: IDLE=0, MOTOR=1, WAIT_DROP=2, SOLENOID=3, GAP=4, FAULT=5);
  - default timing constants;
  - the PEND_W default.
- One natural sub-module, vend_pend_cnt: a saturating up/down counter with a drop flag, instantiated twice (cola and change).

Test Plan:
- Single cola: after reset, pulse pi_cola_req at cycle 10 and pulse pi_drop_sense 5 cycles after the motor drops → cola_pend 1 then 0, po_motor_en high exactly 50 cycles, GAP of 4 cycles, back to IDLE, po_busy low.
- Priority: pulse change at cycle 10 and cola at cycle 10 (same cycle), all drops sensed → motor job runs first, then solenoid high exactly 20 cycles; the two drives never overlap.
- Saturation: 9 cola pulses while in FAULT (PEND_W=3) → cola_pend=7, po_req_drop=1; pi_fault_clr → po_req_drop=0 and 7 motor jobs follow.
- Timeout: cola job with no pi_drop_sense → FAULT exactly 1000 cycles after motor off, po_fault=1 until pi_fault_clr; cola_pend unchanged by the lost can.
- Early sense plus simultaneous events: pi_drop_sense during MOTOR → WAIT_DROP lasts 1 cycle; a request on the same edge as a job start leaves the pend count unchanged.
- Reset mid-job: assert sys_rst at motor cycle 25 → next edge all outputs 0 and pend counts 0. With VEND_DISPENSE_STATS_EN, po_vend_cnt increments only on sensed drops and wraps from 65535 to 0.
